// File: rtl/pacote_mips.sv
// Shared MIPS front-end definitions: fetch FSM state type, NOP encoding and PC step.
package pacote_mips;

    typedef enum logic {
        BUSCA  = 1'b0,
        PARADO = 1'b1
    } estado_t;

    localparam logic [31:0] NOP           = 32'h0000_0000;
    localparam logic [31:0] INCREMENTO_PC = 32'd4;

endpackage

// File: rtl/calcula_proximo_pc.sv
// Combinational next-PC selection: hold (halted or stalled) > jr > salto > desvio > PC+4.
module calcula_proximo_pc
    import pacote_mips::*;
(
    input  logic [31:0] i_pc,
    input  logic        i_parado,
    input  logic        i_stall,
    input  logic        i_desvio,
    input  logic [31:0] i_offset_desvio,
    input  logic        i_salto,
    input  logic [25:0] i_alvo_salto,
    input  logic        i_jr,
    input  logic [31:0] i_reg_alvo,
    output logic [31:0] o_pc_mais4,
    output logic [31:0] o_proximo_pc,
    output logic        o_transferencia
);

    logic [31:0] w_alvo_desvio;
    logic [31:0] w_alvo_salto;
    logic [31:0] w_alvo_jr;

    assign o_pc_mais4      = i_pc + INCREMENTO_PC;
    // Offset is in words; the shift drops its top two bits, matching mod-2^32 wrap.
    assign w_alvo_desvio   = o_pc_mais4 + (i_offset_desvio << 2);
    assign w_alvo_salto    = {o_pc_mais4[31:28], i_alvo_salto, 2'b00};
    assign w_alvo_jr       = i_reg_alvo & ~32'd3;
    assign o_transferencia = i_jr | i_salto | i_desvio;

    always_comb begin
        o_proximo_pc = o_pc_mais4;
        if (i_parado || i_stall) begin
            o_proximo_pc = i_pc;
        end else if (i_jr) begin
            o_proximo_pc = w_alvo_jr;
        end else if (i_salto) begin
            o_proximo_pc = w_alvo_salto;
        end else if (i_desvio) begin
            o_proximo_pc = w_alvo_desvio;
        end
    end

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch unit: PC register, IF/ID register and BUSCA/PARADO FSM.
// Optional valid-fetch counter output enabled with macro BUSCA_CONTADOR_EN.
module unidade_busca
    import pacote_mips::*;
#(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] LIMITE_PC = 32'd36
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        desvio,
    input  logic [31:0] offset_desvio,
    input  logic        salto,
    input  logic [25:0] alvo_salto,
    input  logic        jr,
    input  logic [31:0] reg_alvo,
    input  logic [31:0] instrucao,
    output logic [31:0] endereco,
    output logic [31:0] pc_mais4,
    output logic [31:0] instr_id,
    output logic [31:0] pc_id,
    output logic        valido_id,
    output logic        parado
`ifdef BUSCA_CONTADOR_EN
    ,
    output logic [31:0] contador
`endif
);

    estado_t     r_estado;
    estado_t     w_estado_next;
    logic [31:0] r_pc;
    logic [31:0] r_instr_id;
    logic [31:0] r_pc_id;
    logic        r_valido_id;

    logic [31:0] w_proximo_pc;
    logic        w_transferencia;
    logic        w_fora_limite;
    logic        w_parar;
    logic        w_carrega;
    logic [31:0] w_instr_next;
    logic [31:0] w_pc_id_next;
    logic        w_valido_next;

    assign w_fora_limite = (r_pc > LIMITE_PC);
    // Crossing the limit holds the PC in the same cycle the FSM moves to PARADO.
    assign w_parar       = (r_estado == PARADO) || w_fora_limite;

    calcula_proximo_pc u_calcula_proximo_pc (
        .i_pc            (r_pc),
        .i_parado        (w_parar),
        .i_stall         (stall),
        .i_desvio        (desvio),
        .i_offset_desvio (offset_desvio),
        .i_salto         (salto),
        .i_alvo_salto    (alvo_salto),
        .i_jr            (jr),
        .i_reg_alvo      (reg_alvo),
        .o_pc_mais4      (pc_mais4),
        .o_proximo_pc    (w_proximo_pc),
        .o_transferencia (w_transferencia)
    );

    always_comb begin
        w_estado_next = r_estado;
        w_instr_next  = r_instr_id;
        w_pc_id_next  = r_pc_id;
        w_valido_next = r_valido_id;
        w_carrega     = 1'b0;
        case (r_estado)
            BUSCA: begin
                if (!stall) begin
                    if (w_fora_limite) begin
                        w_estado_next = PARADO;
                        w_instr_next  = NOP;
                        w_valido_next = 1'b0;
                    end else if (w_transferencia) begin
                        w_instr_next  = NOP;
                        w_valido_next = 1'b0;
                    end else begin
                        w_instr_next  = instrucao;
                        w_pc_id_next  = r_pc;
                        w_valido_next = 1'b1;
                        w_carrega     = 1'b1;
                    end
                end
            end
            PARADO: begin
                w_valido_next = 1'b0;
            end
            default: begin
                w_estado_next = BUSCA;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado    <= BUSCA;
            r_pc        <= PC_RESET;
            r_instr_id  <= NOP;
            r_pc_id     <= 32'd0;
            r_valido_id <= 1'b0;
        end else begin
            r_estado    <= w_estado_next;
            r_pc        <= w_proximo_pc;
            r_instr_id  <= w_instr_next;
            r_pc_id     <= w_pc_id_next;
            r_valido_id <= w_valido_next;
        end
    end

`ifdef BUSCA_CONTADOR_EN
    logic [31:0] r_contador;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_contador <= 32'd0;
        end else if (w_carrega && (r_contador != 32'hFFFF_FFFF)) begin
            r_contador <= r_contador + 32'd1;
        end
    end

    assign contador = r_contador;
`endif

    assign endereco  = r_pc;
    assign instr_id  = r_instr_id;
    assign pc_id     = r_pc_id;
    assign valido_id = r_valido_id;
    assign parado    = (r_estado == PARADO);

endmodule

// File: tb/tb_unidade_busca.sv
// Scoreboard bench for unidade_busca: directed scenarios then randomized traffic
// against a cycle-level reference model of the fetch rules.
module tb_unidade_busca;

    localparam logic [31:0] PC_RST = 32'h0000_0000;
    localparam logic [31:0] LIM    = 32'd36;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        desvio = 1'b0;
    logic [31:0] offset_desvio = '0;
    logic        salto = 1'b0;
    logic [25:0] alvo_salto = '0;
    logic        jr = 1'b0;
    logic [31:0] reg_alvo = '0;
    logic [31:0] instrucao;
    logic [31:0] endereco;
    logic [31:0] pc_mais4;
    logic [31:0] instr_id;
    logic [31:0] pc_id;
    logic        valido_id;
    logic        parado;
`ifdef BUSCA_CONTADOR_EN
    logic [31:0] contador;
`endif

    always #5 clk = ~clk;

    // Instruction memory contents are a fixed function of the address.
    function automatic logic [31:0] memoria(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
    endfunction

    assign instrucao = memoria(endereco);

    unidade_busca #(
        .PC_RESET  (PC_RST),
        .LIMITE_PC (LIM)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .desvio        (desvio),
        .offset_desvio (offset_desvio),
        .salto         (salto),
        .alvo_salto    (alvo_salto),
        .jr            (jr),
        .reg_alvo      (reg_alvo),
        .instrucao     (instrucao),
        .endereco      (endereco),
        .pc_mais4      (pc_mais4),
        .instr_id      (instr_id),
        .pc_id         (pc_id),
        .valido_id     (valido_id),
        .parado        (parado)
`ifdef BUSCA_CONTADOR_EN
        ,
        .contador      (contador)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcid;
        logic        val;
        logic        par;
        logic [31:0] cnt;
    } esperado_t;

    esperado_t fila[$];
    int vetores = 0;
    int erros   = 0;
    int ciclo_n = 0;

    // Reference model state
    logic [31:0] m_pc    = '0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_pcid  = '0;
    logic        m_val   = 1'b0;
    logic        m_halt  = 1'b0;
    logic [31:0] m_cnt   = '0;

    task automatic ciclo(input logic rst, input logic st, input logic dv,
                         input logic [31:0] off, input logic sl,
                         input logic [25:0] al, input logic j,
                         input logic [31:0] ra);
        esperado_t e;
        logic [31:0] seq;
        @(negedge clk);
        reset = rst; stall = st; desvio = dv; offset_desvio = off;
        salto = sl; alvo_salto = al; jr = j; reg_alvo = ra;
        seq = m_pc + 32'd4;
        if (rst) begin
            m_pc = PC_RST; m_instr = 0; m_pcid = 0; m_val = 0; m_halt = 0; m_cnt = 0;
        end else if (!m_halt && !st) begin
            if (m_pc > LIM) begin
                m_halt = 1; m_instr = 0; m_val = 0;
            end else if (j || sl || dv) begin
                m_instr = 0; m_val = 0;
                if (j)       m_pc = {ra[31:2], 2'b00};
                else if (sl) m_pc = {seq[31:28], al, 2'b00};
                else         m_pc = seq + off * 32'd4;
            end else begin
                m_instr = memoria(m_pc); m_pcid = m_pc; m_val = 1;
                m_pc = seq;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            end
        end
        e.pc = m_pc; e.instr = m_instr; e.pcid = m_pcid;
        e.val = m_val; e.par = m_halt; e.cnt = m_cnt;
        fila.push_back(e);
    endtask

    task automatic livre(input int n);
        for (int i = 0; i < n; i++) ciclo(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic confere(input string nome, input logic [31:0] atual, input logic [31:0] esp);
        vetores++;
        if (atual !== esp) begin
            erros++;
            $display("FAIL %s ciclo %0d: got %h, expected %h", nome, ciclo_n, atual, esp);
        end
    endtask

    // Monitor: every cycle the DUT presents a new state; compare against the queue.
    initial begin
        esperado_t e;
        forever begin
            @(posedge clk);
            #1;
            if (fila.size() > 0) begin
                e = fila.pop_front();
                ciclo_n++;
                confere("endereco", endereco, e.pc);
                confere("pc_mais4", pc_mais4, e.pc + 32'd4);
                confere("instr_id", instr_id, e.instr);
                confere("pc_id", pc_id, e.pcid);
                confere("valido_id", {31'd0, valido_id}, {31'd0, e.val});
                confere("parado", {31'd0, parado}, {31'd0, e.par});
`ifdef BUSCA_CONTADOR_EN
                confere("contador", contador, e.cnt);
`endif
                $display("ciclo %0d: endereco=%h instr_id=%h pc_id=%h valido=%b parado=%b",
                         ciclo_n, endereco, instr_id, pc_id, valido_id, parado);
            end
        end
    end

    initial begin
        // Reset, then free run: 0, 4, 8
        ciclo(1, 0, 0, 0, 0, 0, 0, 0);
        ciclo(1, 0, 0, 0, 0, 0, 0, 0);
        livre(2);
        // At PC=8 take a branch with offset -2 -> PC=4, flushed IF/ID
        ciclo(0, 0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0);
        livre(3);
        // At PC=0x10: jump to 0x14, then jr 0x1B -> 0x18
        ciclo(0, 0, 0, 0, 1, 26'h5, 0, 0);
        ciclo(0, 0, 0, 0, 0, 0, 1, 32'h0000_001B);
        // Stall at PC=12 with desvio asserted, release with desvio low
        ciclo(1, 0, 0, 0, 0, 0, 0, 0);
        livre(3);
        for (int i = 0; i < 3; i++) ciclo(0, 1, 1, 32'd5, 0, 0, 0, 0);
        livre(1);
        // Run past LIMITE_PC, sit in PARADO ignoring inputs, then reset out
        livre(10);
        ciclo(0, 0, 0, 0, 1, 26'h3, 1, 32'h8);
        livre(4);
        ciclo(1, 1, 1, 0, 1, 0, 1, 0);
        livre(1);
        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            ciclo(($urandom_range(99) < 2),
                  ($urandom_range(99) < 20),
                  ($urandom_range(99) < 10),
                  32'($urandom_range(12)) - 32'd6,
                  ($urandom_range(99) < 5),
                  26'($urandom_range(15)),
                  ($urandom_range(99) < 5),
                  32'($urandom_range(63)));
        end
        @(negedge clk);
        reset = 1'b0; stall = 1'b0; desvio = 1'b0; salto = 1'b0; jr = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        vetores++;
        if (fila.size() != 0) begin
            erros++;
            $display("FAIL fila: %0d entries left, expected 0", fila.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

endmodule

// File: doc/unidade_busca.md
UNIDADE_BUSCA -- requirements
Module: unidade_busca

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter LIMITE_PC, default 32'd36: last valid fetch address (10 words); unsigned compare.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  in  1  hold PC and IF/ID contents.
REQ-006 SHALL have port desvio  in  1  conditional branch taken.
REQ-007 SHALL have port offset_desvio  in  32  sign-extended branch immediate, in words.
REQ-008 SHALL have port salto  in  1  J-type jump.
REQ-009 SHALL have port alvo_salto  in  26  jump target field.
REQ-010 SHALL have port jr  in  1  jump-register.
REQ-011 SHALL have port reg_alvo  in  32  jump-register target.
REQ-012 SHALL have port instrucao  in  32  word returned by instruction memory for endereco.
REQ-013 SHALL have port endereco  out  32  current PC, driven to instruction memory.
REQ-014 SHALL have port pc_mais4  out  32  PC+4.
REQ-015 SHALL have port instr_id  out  32  registered instruction (IF/ID).
REQ-016 SHALL have port pc_id  out  32  PC of instr_id.
REQ-017 SHALL have port valido_id  out  1  instr_id valid.
REQ-018 SHALL have port parado  out  1  fetch halted past LIMITE_PC.

Function
REQ-019 SHALL drive endereco combinationally from the PC register; pc_mais4 = PC+4, wrapping mod 2^32.
REQ-020 SHALL select next PC by priority: reset > parado > stall (hold) > jr > salto > desvio > pc_mais4.
REQ-021 SHALL compute branch target = pc_mais4 + (offset_desvio << 2), wrapping mod 2^32.
REQ-022 SHALL compute jump target = {pc_mais4[31:28], alvo_salto, 2'b00}.
REQ-023 SHALL use jr target = {reg_alvo[31:2], 2'b00}; low bits are discarded.
REQ-024 SHALL implement FSM states BUSCA and PARADO; reset enters BUSCA; only reset leaves PARADO.
REQ-025 In BUSCA, with stall low and PC > LIMITE_PC, SHALL move to PARADO the next cycle, load instr_id=0 and valido_id=0, and hold PC.
REQ-026 In BUSCA, with stall low and PC <= LIMITE_PC, SHALL load instr_id=instrucao, pc_id=PC, and valido_id=1 one cycle after endereco is presented.
REQ-027 When any of desvio/salto/jr is asserted without stall, SHALL flush IF/ID (instr_id=0, valido_id=0) and load the target PC.
REQ-028 With stall high, SHALL hold PC, instr_id, pc_id and valido_id, and ignore desvio/salto/jr in that cycle.
REQ-029 In PARADO, SHALL hold parado=1, valido_id=0 and PC, and ignore all inputs except reset.

Reset
REQ-030 On reset, SHALL set PC=PC_RESET, instr_id=0, pc_id=0, valido_id=0, parado=0, state BUSCA, at the next rising edge.
REQ-031 Reset SHALL override stall, control transfers and PARADO in the same cycle.

Configuration
REQ-032 With macro BUSCA_CONTADOR_EN defined, SHALL add output contador (out, 32 bits) that counts cycles loading valido_id=1, resets to 0, and saturates at 32'hFFFF_FFFF.
REQ-033 Without BUSCA_CONTADOR_EN, SHALL have neither the contador port nor its logic.

Structure
REQ-034 SHALL take from shared package pacote_mips: the FSM state type (BUSCA, PARADO), the NOP constant 32'h0 and the PC increment constant 4.
REQ-035 SHALL place next-PC selection in one combinational sub-module, calcula_proximo_pc; the PC, IF/ID and FSM registers SHALL reside in unidade_busca.

Verification
REQ-036 Reset, then 3 free-running cycles -> endereco 0,4,8; instr_id lags endereco by one cycle; valido_id=1 from cycle 2.
REQ-037 At PC=8, desvio=1 with offset_desvio=-2 -> next PC=4; next cycle valido_id=0 and instr_id=0.
REQ-038 At PC=0x0000_0010, salto=1 with alvo_salto=26'h5 -> PC=0x0000_0014; jr=1 with reg_alvo=0x0000_001B -> PC=0x0000_0018.
REQ-039 stall held 3 cycles at PC=12 while desvio=1 -> PC, instr_id and valido_id unchanged; PC=16 after release when desvio is low.
REQ-040 Free run from 0 -> PC=40 then parado=1 and valido_id=0 indefinitely; reset asserted in PARADO -> PC=0 and parado=0.
REQ-041 With BUSCA_CONTADOR_EN: 10 valid fetches, one flush, then halt -> contador=10.
